// File: rtl/debounce_bank_if.sv
// Bundle of raw inputs and debounced outputs for debounce_bank.
// The master modport belongs to whoever drives the raw inputs. The slave modport is the debouncer itself.
interface debounce_bank_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] noisy;
  logic [NCH-1:0] clean;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic [NCH-1:0] rpt;
  logic           any_change;

  modport master (
    output noisy,
    input  clean, rise, fall, rpt, any_change
  );

  modport slave (
    input  noisy,
    output clean, rise, fall, rpt, any_change
  );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel debouncer. Each channel has a synchroniser, a stability filter,
// one-cycle edge strobes and an optional auto-repeat strobe.
module debounce_bank #(
  parameter int NCH           = 4,
  parameter int NDELAY        = 20,
  parameter int NBITS         = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_PERIOD = 0,
  parameter int RBITS         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  debounce_bank_if.slave  bus
);

  if (NDELAY > (1 << NBITS) - 1) begin : g_chk_ndelay
    $error("debounce_bank: NDELAY does not fit in NBITS");
  end
  if (SYNC_STAGES < 1) begin : g_chk_sync
    $error("debounce_bank: SYNC_STAGES must be at least 1");
  end
  if (REPEAT_PERIOD < 0 || longint'(REPEAT_PERIOD) > (longint'(1) << RBITS)) begin : g_chk_rpt
    $error("debounce_bank: REPEAT_PERIOD out of range for RBITS");
  end

  localparam logic [NBITS-1:0] NDELAY_C = NBITS'(NDELAY);

  logic [NCH-1:0] clean_v;
  logic [NCH-1:0] rise_v;
  logic [NCH-1:0] fall_v;
  logic [NCH-1:0] rpt_v;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   xnew_q;
    logic [NBITS-1:0]       count_q;
    logic                   clean_q;
    logic                   clean_d;
    logic                   rise_q;
    logic                   fall_q;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
      clean_d = clean_q;
      if (s == xnew_q && count_q == NDELAY_C) clean_d = xnew_q;
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops,
    // including the synchroniser, clear on reset so no stale sample causes a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        xnew_q  <= 1'b0;
        count_q <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        sync_q <= (sync_q << 1) | SYNC_STAGES'(bus.noisy[i]);
        if (s != xnew_q) begin
          xnew_q  <= s;
          count_q <= '0;
        end else if (count_q != NDELAY_C) begin
          count_q <= count_q + 1'b1;
        end
        clean_q <= clean_d;
        rise_q  <= clean_d & ~clean_q;
        fall_q  <= ~clean_d & clean_q;
      end
    end

    assign clean_v[i] = clean_q;
    assign rise_v[i]  = rise_q;
    assign fall_v[i]  = fall_q;

    if (REPEAT_PERIOD > 0) begin : g_rpt
      localparam logic [RBITS-1:0] RLAST = RBITS'(REPEAT_PERIOD - 1);
      logic [RBITS-1:0] rcnt_q;
      logic             rpt_q;

      // The first pulse coincides with the rise, then one pulse every REPEAT_PERIOD cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rcnt_q <= '0;
          rpt_q  <= 1'b0;
        end else if (clean_d && !clean_q) begin
          rcnt_q <= '0;
          rpt_q  <= 1'b1;
        end else if (clean_d && clean_q) begin
          if (rcnt_q == RLAST) begin
            rcnt_q <= '0;
            rpt_q  <= 1'b1;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
            rpt_q  <= 1'b0;
          end
        end else begin
          rcnt_q <= '0;
          rpt_q  <= 1'b0;
        end
      end

      assign rpt_v[i] = rpt_q;
    end else begin : g_no_rpt
      assign rpt_v[i] = 1'b0;
    end
  end

  assign bus.clean      = clean_v;
  assign bus.rise       = rise_v;
  assign bus.fall       = fall_v;
  assign bus.rpt        = rpt_v;
  assign bus.any_change = |(rise_v | fall_v);

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank. Stimulus queues the expected strobe events by edge number.
// A negedge monitor pops one expected event each time the DUT shows a strobe and compares the two.
module tb_debounce_bank;
  localparam int NCH = 4;
  localparam int P   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debounce_bank_if #(.NCH(NCH)) bus ();

  debounce_bank #(
    .NCH(NCH), .NDELAY(20), .NBITS(5), .SYNC_STAGES(2),
    .REPEAT_PERIOD(P), .RBITS(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int             cyc;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] rpt;
  } ev_t;

  ev_t            exp_q[$];
  int             cyc       = 0;
  int             n_checks  = 0;
  int             n_fail    = 0;
  logic [NCH-1:0] exp_clean = '0;

  // cyc holds the number of the most recent rising edge.
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Insert an expected strobe in edge order. Strobes on the same edge merge into one event.
  task automatic expect_ev(input int c, input int ch, input bit r, input bit f, input bit p);
    ev_t e;
    int  idx = exp_q.size();
    for (int j = 0; j < exp_q.size(); j++) begin
      if (exp_q[j].cyc == c) begin
        e = exp_q[j];
        e.rise[ch] = e.rise[ch] | r;
        e.fall[ch] = e.fall[ch] | f;
        e.rpt[ch]  = e.rpt[ch] | p;
        exp_q[j] = e;
        return;
      end
      if (exp_q[j].cyc > c) begin
        idx = j;
        break;
      end
    end
    e.cyc  = c;
    e.rise = '0;
    e.fall = '0;
    e.rpt  = '0;
    e.rise[ch] = r;
    e.fall[ch] = f;
    e.rpt[ch]  = p;
    exp_q.insert(idx, e);
  endtask

  task automatic expect_rpt(input int c_from, input int c_to, input int ch);
    for (int c = c_from; c <= c_to; c += P) expect_ev(c, ch, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clean"}, 32'(bus.clean), 32'h0);
    check({tag, "_rise"},  32'(bus.rise),  32'h0);
    check({tag, "_fall"},  32'(bus.fall),  32'h0);
    check({tag, "_rpt"},   32'(bus.rpt),   32'h0);
    check({tag, "_any"},   32'(bus.any_change), 32'h0);
  endtask

  // Monitor
  always @(negedge clk) begin : monitor
    ev_t e;
    if (!rst_n) begin
      exp_clean = '0;
    end else if ((bus.rise | bus.fall | bus.rpt) != '0 || bus.any_change) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe at edge %0d: rise=%b fall=%b rpt=%b any=%b, expected none",
                 cyc, bus.rise, bus.fall, bus.rpt, bus.any_change);
      end else begin
        e = exp_q.pop_front();
        exp_clean = (exp_clean | e.rise) & ~e.fall;
        check("event_edge", 32'(cyc), 32'(e.cyc));
        check("rise", 32'(bus.rise), 32'(e.rise));
        check("fall", 32'(bus.fall), 32'(e.fall));
        check("rpt",  32'(bus.rpt),  32'(e.rpt));
        check("clean", 32'(bus.clean), 32'(exp_clean));
        check("any_change", 32'(bus.any_change), 32'(|(e.rise | e.fall)));
      end
    end
  end

  initial begin : stimulus
    int k;
    int r;
    bus.noisy = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(30);

    // Clean step on channel 0 with repeat pulses, then release.
    k = cyc;
    bus.noisy[0] = 1'b1;
    expect_ev(k + 24, 0, 1'b1, 1'b0, 1'b0);
    expect_rpt(k + 24, k + 48, 0);
    step(30);
    bus.noisy[0] = 1'b0;
    expect_ev(k + 54, 0, 1'b0, 1'b1, 1'b0);
    step(40);

    // Glitch threshold on channel 1: 21 edges high is rejected, 22 edges high is accepted.
    bus.noisy[1] = 1'b1;
    step(21);
    bus.noisy[1] = 1'b0;
    step(30);
    k = cyc;
    bus.noisy[1] = 1'b1;
    expect_ev(k + 24, 1, 1'b1, 1'b0, 1'b0);
    expect_rpt(k + 24, k + 40, 1);
    step(22);
    bus.noisy[1] = 1'b0;
    expect_ev(k + 46, 1, 1'b0, 1'b1, 1'b0);
    step(40);

    // Bounce on channel 2: toggle every 3 cycles, then settle high.
    k = cyc;
    for (int i = 0; i < 14; i++) begin
      bus.noisy[2] = (i % 2 == 0);
      step(3);
    end
    bus.noisy[2] = 1'b1;
    expect_ev(k + 66, 2, 1'b1, 1'b0, 1'b0);
    expect_rpt(k + 66, k + 90, 2);
    step(30);
    bus.noisy[2] = 1'b0;
    expect_ev(k + 96, 2, 1'b0, 1'b1, 1'b0);
    step(40);

    // Auto-repeat on channel 3.
    k = cyc;
    bus.noisy[3] = 1'b1;
    expect_ev(k + 24, 3, 1'b1, 1'b0, 1'b0);
    expect_rpt(k + 24, k + 72, 3);
    step(50);
    bus.noisy[3] = 1'b0;
    expect_ev(k + 74, 3, 1'b0, 1'b1, 1'b0);
    step(40);

    // Simultaneous events: channel 0 rises while channel 1 falls.
    k = cyc;
    bus.noisy[1] = 1'b1;
    expect_ev(k + 24, 1, 1'b1, 1'b0, 1'b0);
    expect_rpt(k + 24, k + 48, 1);
    step(30);
    bus.noisy[0] = 1'b1;
    bus.noisy[1] = 1'b0;
    expect_ev(k + 54, 0, 1'b1, 1'b0, 1'b0);
    expect_ev(k + 54, 1, 1'b0, 1'b1, 1'b0);
    expect_rpt(k + 54, k + 78, 0);
    step(30);
    bus.noisy[0] = 1'b0;
    expect_ev(k + 84, 0, 1'b0, 1'b1, 1'b0);
    step(40);

    // Reset mid-repeat on channel 3 and mid-count on channel 0.
    k = cyc;
    bus.noisy[3] = 1'b1;
    expect_ev(k + 24, 3, 1'b1, 1'b0, 1'b0);
    expect_rpt(k + 24, k + 40, 3);
    step(30);
    bus.noisy[0] = 1'b1;
    step(15);
    check("pre_reset_clean", 32'(bus.clean), 32'h8);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    step(3);
    rst_n = 1'b1;
    r = cyc;
    expect_ev(r + 24, 0, 1'b1, 1'b0, 1'b0);
    expect_ev(r + 24, 3, 1'b1, 1'b0, 1'b0);
    expect_rpt(r + 24, r + 48, 0);
    expect_rpt(r + 24, r + 48, 3);
    step(30);
    bus.noisy[0] = 1'b0;
    bus.noisy[3] = 1'b0;
    expect_ev(r + 54, 0, 1'b0, 1'b1, 1'b0);
    expect_ev(r + 54, 3, 1'b0, 1'b1, 1'b0);
    step(40);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check_all_zero("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
